mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between two requesters: port 0 (word

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/arb_wait_counter.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-port memory arbiter.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic PORT0          = 1'b0;
    localparam logic PORT1          = 1'b1;
    // Port 1 counts as the previous owner out of reset so port 0 wins the
    // first contention.
    localparam logic LAST_OWNER_RST = PORT1;

    // Round-robin pick: a lone requester always wins; under contention the
    // port that did not own the memory last time wins.
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic last_owner);
        if (r0 && r1) begin
            return ~last_owner;
        end
        return r1 ? PORT1 : PORT0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : arb_wait_counter
// Purpose  : Loadable down-counter with zero flag; paces the fixed memory
//            latency of one access.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module arb_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active-low
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load has priority over decrement; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter sharing one single-port, fixed-latency memory
//            between a word port (0) and a byte port (1).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active-low
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [7:0]    wdata1,
    input  logic          we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          mux_sel,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int          CW       = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    arb_state_t    state_q,      state_d;
    logic          mux_sel_q,    mux_sel_d;
    logic          last_owner_q, last_owner_d;
    logic          gnt0_q,       gnt0_d;
    logic          gnt1_q,       gnt1_d;
    logic          done0_q,      done0_d;
    logic          done1_q,      done1_d;
    logic          mem_en_q,     mem_en_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DW-1:0] rdata_q,      rdata_d;

    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          winner;

    arb_wait_counter #(
        .WIDTH (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign winner = pick_winner(req0, req1, last_owner_q);

    // Next-state and registered-output logic: grant latches the winner's
    // request, BUSY counts out the memory latency, DONE pulses completion.
    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        last_owner_d = last_owner_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = BUSY;
                    mux_sel_d    = winner;
                    last_owner_d = winner;
                    cnt_load     = 1'b1;
                    mem_en_d     = 1'b1;
                    if (winner == PORT1) begin
                        gnt1_d      = 1'b1;
                        mem_we_d    = we1;
                        mem_addr_d  = addr1;
                        mem_wdata_d = DW'(wdata1);
                    end else begin
                        gnt0_d      = 1'b1;
                        mem_we_d    = we0;
                        mem_addr_d  = addr0;
                        mem_wdata_d = wdata0;
                    end
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done0_d  = (mux_sel_q == PORT0);
                    done1_d  = (mux_sel_q == PORT1);
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mux_sel_q    <= PORT0;
            last_owner_q <= LAST_OWNER_RST;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            last_owner_q <= last_owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mux_sel   = mux_sel_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (latency 2 main build,
//            latency 1 secondary build) against a transaction-level model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0, wdata1 = '0;
    logic [15:0] wdata0 = '0;
    logic        gnt0, gnt1, done0, done1, mux_sel, mem_en, mem_we;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    // secondary latency-1 instance
    logic        b_req0 = 1'b0;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_mux_sel, b_mem_en, b_mem_we;
    logic [15:0] b_rdata, b_mem_wdata;
    logic [7:0]  b_mem_addr;

    // behavioural memory
    logic [15:0] mem_arr [256];
    logic        init_we = 1'b0;
    logic [7:0]  init_addr = '0;
    logic [15:0] init_data = '0;

    // reference model state
    logic [15:0] ref_mem [256];
    logic        last_owner;
    logic [15:0] exp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DW(16), .AW(8), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mux_sel(mux_sel), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.DW(16), .AW(8), .MEM_LATENCY(1)) dut_lat1 (
        .clk(clk), .reset(reset),
        .req0(b_req0), .addr0(8'h33), .wdata0(16'h0000), .we0(1'b0),
        .req1(1'b0), .addr1(8'h00), .wdata1(8'h00), .we1(1'b0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata(b_rdata), .mux_sel(b_mux_sel), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(16'h1234)
    );

    // Memory: preload port during reset, otherwise writes from the arbiter.
    always @(posedge clk) begin
        if (init_we) begin
            mem_arr[init_addr] <= init_data;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_arr[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One arbitrated access. Called at a negedge while the DUT is idle; raises
    // the requested ports (ports already pending keep their fields), predicts
    // the winner and checks every cycle through to the following idle cycle.
    task automatic run_txn(input bit new0, input bit new1, input bit drop_early);
        logic        w;
        logic        wr;
        logic [7:0]  a;
        logic [15:0] wd;
        if (new0 && !req0) begin
            addr0 = 8'($urandom); wdata0 = 16'($urandom);
            we0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
        end
        if (new1 && !req1) begin
            addr1 = 8'($urandom); wdata1 = 8'($urandom);
            we1 = 1'($urandom_range(0, 1)); req1 = 1'b1;
        end
        if (!req0 && !req1) return;
        w  = (req0 && req1) ? ~last_owner : req1;
        last_owner = w;
        a  = w ? addr1 : addr0;
        wr = w ? we1 : we0;
        wd = w ? {8'h00, wdata1} : wdata0;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c <= LAT) begin
                check("gnt0",      gnt0, (c == 1) && !w);
                check("gnt1",      gnt1, (c == 1) && w);
                check("mem_en",    mem_en, 1);
                check("mem_we",    mem_we, wr);
                check("mem_addr",  mem_addr, a);
                check("mem_wdata", mem_wdata, wd);
                check("mux_sel",   mux_sel, w);
                check("done_busy", {done1, done0}, 0);
                if (c == 1 && drop_early) begin
                    if (w) req1 = 1'b0; else req0 = 1'b0;
                end
            end else begin
                if (wr) ref_mem[a] = wd;
                else    exp_rdata  = ref_mem[a];
                check("done0",     done0, !w);
                check("done1",     done1, w);
                check("mem_en_dn", mem_en, 0);
                check("mem_we_dn", mem_we, 0);
                check("rdata",     rdata, exp_rdata);
                check("gnt_dn",    {gnt1, gnt0}, 0);
                if (w) req1 = 1'b0; else req0 = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_mem_en", mem_en, 0);
        check("idle_pulses", {gnt1, gnt0, done1, done0}, 0);
        check("idle_mux",    mux_sel, w);
    endtask

    // One cycle with no request pending: nothing may start.
    task automatic idle_cycle();
        logic m;
        m = mux_sel === 1'b1;
        @(negedge clk);
        check("noreq_gnt",    {gnt1, gnt0}, 0);
        check("noreq_mem_en", mem_en, 0);
        check("noreq_mux",    mux_sel, m);
        check("noreq_rdata",  rdata, exp_rdata);
    endtask

    initial begin
        last_owner = 1'b1;
        exp_rdata  = '0;

        // reset values
        #1;
        check("rst_gnt",   {gnt1, gnt0}, 0);
        check("rst_done",  {done1, done0}, 0);
        check("rst_mem",   {mem_en, mem_we}, 0);
        check("rst_mux",   mux_sel, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);

        // preload memory and the reference image while in reset
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            init_we   = 1'b1;
            init_addr = 8'(i);
            init_data = (i == 16'h10) ? 16'hBEEF : 16'($urandom);
            ref_mem[i] = init_data;
        end
        @(negedge clk);
        init_we = 1'b0;
        reset   = 1'b1;
        @(negedge clk);

        // 1: port 0 read
        addr0 = 8'h10; we0 = 1'b0; req0 = 1'b1;
        run_txn(0, 0, 0);
        check("t1_rdata", rdata, 16'hBEEF);

        // 2: port 1 byte write, rdata must keep BEEF
        addr1 = 8'h20; wdata1 = 8'hA5; we1 = 1'b1; req1 = 1'b1;
        run_txn(0, 0, 0);
        check("t2_mem", ref_mem[8'h20], mem_arr[8'h20]);

        // 3: sustained contention alternates 0,1,0,1
        run_txn(1, 1, 0);
        for (int i = 0; i < 3; i++) run_txn(1, 1, 0);
        req0 = 1'b0; req1 = 1'b0;
        idle_cycle();

        // 4: port 0 drops its request right after the grant
        run_txn(1, 0, 1);
        idle_cycle();
        idle_cycle();

        // 5: reset in the middle of an access
        addr0 = 8'h44; we0 = 1'b0; req0 = 1'b1;
        @(negedge clk);
        check("t5_gnt0", gnt0, 1);
        reset = 1'b0;
        #1;
        check("t5_mem_en", mem_en, 0);
        check("t5_gnt",    {gnt1, gnt0}, 0);
        check("t5_done",   {done1, done0}, 0);
        check("t5_mux",    mux_sel, 0);
        check("t5_addr",   mem_addr, 0);
        check("t5_rdata",  rdata, 0);
        last_owner = 1'b1;
        exp_rdata  = '0;
        @(negedge clk);
        reset = 1'b1;
        run_txn(0, 1, 0);   // req0 still pending, req1 joins: port 0 wins

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit n0, n1, dr;
            n0 = 1'($urandom_range(0, 1));
            n1 = 1'($urandom_range(0, 1));
            dr = ($urandom_range(0, 3) == 0);
            if (!n0 && !n1 && !req0 && !req1) idle_cycle();
            else run_txn(n0, n1, dr);
        end
        req0 = 1'b0; req1 = 1'b0;
        idle_cycle();

        // 6: latency-1 build
        b_req0 = 1'b1;
        @(negedge clk);
        check("t6_gnt0",    b_gnt0, 1);
        check("t6_mem_en",  b_mem_en, 1);
        check("t6_addr",    b_mem_addr, 8'h33);
        check("t6_done_e",  b_done0, 0);
        @(negedge clk);
        check("t6_done0",   b_done0, 1);
        check("t6_mem_en0", b_mem_en, 0);
        check("t6_rdata",   b_rdata, 16'h1234);
        b_req0 = 1'b0;
        @(negedge clk);
        check("t6_idle",    {b_mem_en, b_gnt0, b_done0, b_gnt1, b_done1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
